// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, done and frame-error strobes
module uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic [7:0] uart_data_out,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int BIT_CNT  = CLK_FREQ / UART_BPS;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam logic [8:0] BIT_LAST  = 9'(BIT_CNT - 1);
    localparam logic [8:0] HALF_LAST = 9'(HALF_CNT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t     state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_out_q, data_out_d;
    logic       rx_done_q, rx_done_d;
    logic       frame_err_q, frame_err_d;
    logic       rx_busy_q, rx_busy_d;
    logic       rxd_meta_q, rxd_s_q, rxd_dly_q;

    // Synchronizer flops idle at line level so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            rxd_dly_q  <= 1'b1;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_s_q    <= rxd_meta_q;
            rxd_dly_q  <= rxd_s_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_out_q  <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_out_q  <= data_out_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= rx_busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_out_d  = data_out_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        rx_busy_d   = rx_busy_q;
        case (state_q)
            IDLE: begin
                if (rxd_dly_q && !rxd_s_q) begin
                    state_d   = START;
                    cnt_d     = '0;
                    rx_busy_d = 1'b1;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    // Line high again at mid-start means the edge was a glitch.
                    if (!rxd_s_q) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d   = IDLE;
                        rx_busy_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rxd_s_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    state_d   = IDLE;
                    rx_busy_d = 1'b0;
                    if (rxd_s_q) begin
                        data_out_d = shift_q;
                        rx_done_d  = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                rx_busy_d = 1'b0;
            end
        endcase
    end

    assign uart_data_out = data_out_q;
    assign rx_done       = rx_done_q;
    assign frame_err     = frame_err_q;
    assign rx_busy       = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed-vector bench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_NS = 8681;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [7:0] uart_data_out;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    int    vectors = 0;
    int    miscompares = 0;
    int    done_cnt = 0;
    int    ferr_cnt = 0;
    logic  prev_strobe = 1'b0;
    time   done_t [0:31];
    logic [7:0] done_data [0:31];
    time   t_fall;

    uart_rx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart_rxd      (uart_rxd),
        .uart_data_out (uart_data_out),
        .rx_done       (rx_done),
        .frame_err     (frame_err),
        .rx_busy       (rx_busy)
    );

    always #10 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: log every done pulse, count frame errors, check exclusivity.
    always @(negedge clk) begin
        if (rx_done || frame_err) begin
            check_vec("strobe_exclusive", {30'd0, rx_done, frame_err} == 32'd3 ? 32'd1 : 32'd0, 32'd0);
            check_vec("strobe_not_back_to_back", {31'd0, prev_strobe}, 32'd0);
        end
        if (rx_done) begin
            if (done_cnt < 32) begin
                done_t[done_cnt]    = $time;
                done_data[done_cnt] = uart_data_out;
            end
            done_cnt++;
        end
        if (frame_err) ferr_cnt++;
        prev_strobe = rx_done | frame_err;
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rxd = 1'b0;
        t_fall   = $time;
        #BIT_NS;
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            #BIT_NS;
        end
        uart_rxd = stop_bit;
        #BIT_NS;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    int d0, f0;
    int lat;

    initial begin
        // Reset state
        wait_clk(5);
        check_vec("reset_data", {24'd0, uart_data_out}, 32'h00);
        check_vec("reset_done", {31'd0, rx_done}, 32'd0);
        check_vec("reset_ferr", {31'd0, frame_err}, 32'd0);
        check_vec("reset_busy", {31'd0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        wait_clk(20);

        // 1: single frame 0xC9, latency ~4123 clk from edge detect (+3 synchronizer)
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'hC9, 1'b1);
        wait_clk(5);
        check_vec("c9_done_count", done_cnt - d0, 1);
        check_vec("c9_data", {24'd0, uart_data_out}, 32'hC9);
        check_vec("c9_no_ferr", ferr_cnt - f0, 0);
        lat = int'((done_t[d0] - t_fall) / 20);
        check_vec("c9_latency_window", (lat >= 4122 && lat <= 4130) ? 1 : 0, 1);

        // 2: back-to-back 0x55, 0xAA
        d0 = done_cnt;
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        wait_clk(5);
        check_vec("b2b_done_count", done_cnt - d0, 2);
        check_vec("b2b_first", {24'd0, done_data[d0]}, 32'h55);
        check_vec("b2b_second", {24'd0, done_data[d0+1]}, 32'hAA);
        lat = int'((done_t[d0+1] - done_t[d0]) / 20);
        check_vec("b2b_spacing_window", (lat >= 4336 && lat <= 4345) ? 1 : 0, 1);

        // 3: 100 ns glitch on idle line
        d0 = done_cnt; f0 = ferr_cnt;
        @(negedge clk);
        uart_rxd = 1'b0;
        #100;
        uart_rxd = 1'b1;
        wait_clk(10);
        check_vec("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
        wait_clk(300);
        check_vec("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
        check_vec("glitch_no_done", done_cnt - d0, 0);
        check_vec("glitch_no_ferr", ferr_cnt - f0, 0);
        check_vec("glitch_data_held", {24'd0, uart_data_out}, 32'hAA);

        // 4: low stop bit, then break held 20 bits, then recovery with 0x81
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        #(20 * BIT_NS);
        check_vec("ferr_count", ferr_cnt - f0, 1);
        check_vec("ferr_no_done", done_cnt - d0, 0);
        check_vec("ferr_data_held", {24'd0, uart_data_out}, 32'hAA);
        check_vec("break_not_busy", {31'd0, rx_busy}, 32'd0);
        uart_rxd = 1'b1;
        #(2 * BIT_NS);
        send_frame(8'h81, 1'b1);
        wait_clk(5);
        check_vec("recover_done_count", done_cnt - d0, 1);
        check_vec("recover_data", {24'd0, uart_data_out}, 32'h81);
        check_vec("recover_ferr_count", ferr_cnt - f0, 1);

        // 5: reset mid data bit 4 of 0xF0
        d0 = done_cnt;
        @(negedge clk);
        uart_rxd = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 4; i++) begin
            uart_rxd = 1'b0;
            #BIT_NS;
        end
        uart_rxd = 1'b1;
        #(BIT_NS / 2);
        rst_n = 1'b0;
        #1;
        check_vec("midreset_data", {24'd0, uart_data_out}, 32'h00);
        check_vec("midreset_busy", {31'd0, rx_busy}, 32'd0);
        check_vec("midreset_done", {31'd0, rx_done}, 32'd0);
        #99;
        rst_n = 1'b1;
        #(6 * BIT_NS);
        check_vec("midreset_no_done", done_cnt - d0, 0);
        send_frame(8'h12, 1'b1);
        wait_clk(5);
        check_vec("after_reset_data", {24'd0, uart_data_out}, 32'h12);

        // 6: transmitter-style frames 0x93, 0x00, 0xFF
        d0 = done_cnt;
        send_frame(8'h93, 1'b1);
        wait_clk(5);
        check_vec("tx93_data", {24'd0, uart_data_out}, 32'h93);
        send_frame(8'h00, 1'b1);
        wait_clk(5);
        check_vec("tx00_data", {24'd0, uart_data_out}, 32'h00);
        send_frame(8'hFF, 1'b1);
        wait_clk(5);
        check_vec("txff_data", {24'd0, uart_data_out}, 32'hFF);
        check_vec("tx_done_count", done_cnt - d0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
